// File: rtl/n1_pkg.sv
// -----------------------------------------------------------------------------
// n1_pkg
// Shared constants and saturation helpers for the n1 accumulate unit.
//   N        : width of each product and of the final result
//   TN       : products per input beat (power of two)
//   ACC_W    : running-accumulator width
//   LOG2_TN  : adder-tree depth (one register per level)
//   TREE_W   : adder-tree output width, N + LOG2_TN
//   WIDE_W   : width of acc + tree_sum before saturation (never overflows)
// -----------------------------------------------------------------------------
package n1_pkg;

   localparam int N       = 16;
   localparam int TN      = 16;
   localparam int ACC_W   = 24;
   localparam int LOG2_TN = $clog2(TN);
   localparam int TREE_W  = N + LOG2_TN;
   // One guard bit over the accumulator is enough: TREE_W < ACC_W.
   localparam int WIDE_W  = ACC_W + 1;

   // Clip limits for the N-bit result, both as N-bit values and sign-extended
   // to WIDE_W so they can be compared against the unsaturated sum.
   localparam logic [N-1:0]             N_MAX     = {1'b0, {(N-1){1'b1}}};
   localparam logic [N-1:0]             N_MIN     = {1'b1, {(N-1){1'b0}}};
   localparam logic signed [WIDE_W-1:0] N_MAX_W   = {{(WIDE_W-N+1){1'b0}}, {(N-1){1'b1}}};
   localparam logic signed [WIDE_W-1:0] N_MIN_W   = {{(WIDE_W-N+1){1'b1}}, {(N-1){1'b0}}};

   // Clip limits for the ACC_W-bit accumulator.
   localparam logic [ACC_W-1:0]         ACC_MAX   = {1'b0, {(ACC_W-1){1'b1}}};
   localparam logic [ACC_W-1:0]         ACC_MIN   = {1'b1, {(ACC_W-1){1'b0}}};
   localparam logic signed [WIDE_W-1:0] ACC_MAX_W = {2'b00, {(ACC_W-1){1'b1}}};
   localparam logic signed [WIDE_W-1:0] ACC_MIN_W = {2'b11, {(ACC_W-1){1'b0}}};

   // Saturated N-bit result together with the "was clipped" flag.
   typedef struct packed {
      logic [N-1:0] value;
      logic         clipped;
   } sat_n_t;

   // Sign-extend accumulator and tree sum to WIDE_W and add them.
   function automatic logic [WIDE_W-1:0] widen_sum(input logic [ACC_W-1:0]  acc,
                                                   input logic [TREE_W-1:0] tree);
      logic [WIDE_W-1:0] acc_w;
      logic [WIDE_W-1:0] tree_w;
      acc_w  = {acc[ACC_W-1], acc};
      tree_w = {{(WIDE_W-TREE_W){tree[TREE_W-1]}}, tree};
      return acc_w + tree_w;
   endfunction

   // Clip a WIDE_W signed value to the N-bit signed range.
   function automatic sat_n_t sat_n(input logic signed [WIDE_W-1:0] x);
      sat_n_t r;
      if (x > N_MAX_W) begin
         r.value   = N_MAX;
         r.clipped = 1'b1;
      end else if (x < N_MIN_W) begin
         r.value   = N_MIN;
         r.clipped = 1'b1;
      end else begin
         r.value   = x[N-1:0];
         r.clipped = 1'b0;
      end
      return r;
   endfunction

   // Clip a WIDE_W signed value to the ACC_W-bit signed range.
   function automatic logic [ACC_W-1:0] sat_acc(input logic signed [WIDE_W-1:0] x);
      logic [ACC_W-1:0] r;
      if (x > ACC_MAX_W) begin
         r = ACC_MAX;
      end else if (x < ACC_MIN_W) begin
         r = ACC_MIN;
      end else begin
         r = x[ACC_W-1:0];
      end
      return r;
   endfunction

endpackage

// File: rtl/n1_add_tree.sv
// -----------------------------------------------------------------------------
// n1_add_tree
// Pipelined binary adder tree: sums TN signed N-bit products in LOG2_TN
// registered levels. Level l widens its operands by one bit (N+l -> N+l+1),
// so no level can overflow. valid/last ride alongside in a shift pipeline of
// the same depth so they stay aligned with the sum.
// Ports:
//   clk      in   clock
//   rst      in   synchronous active-high reset (clears the valid pipeline)
//   valid_i  in   a beat of TN products is present
//   last_i   in   beat closes the current output window
//   prod_i   in   TN packed signed products, lane k at [(k+1)*N-1 : k*N]
//   valid_o  out  sum_o carries a beat's total this cycle
//   last_o   out  that beat was the last of its window
//   sum_o    out  TREE_W-bit signed sum of the beat's TN products
// -----------------------------------------------------------------------------
module n1_add_tree
   import n1_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              valid_i,
   input  logic              last_i,
   input  logic [TN*N-1:0]   prod_i,
   output logic              valid_o,
   output logic              last_o,
   output logic [TREE_W-1:0] sum_o
);

   logic [LOG2_TN-1:0] valid_q;
   logic [LOG2_TN-1:0] valid_d;
   logic [LOG2_TN-1:0] last_q;
   logic [LOG2_TN-1:0] last_d;

   // Shift the beat qualifiers one level deeper each cycle.
   always_comb begin
      valid_d = {valid_q[LOG2_TN-2:0], valid_i};
      last_d  = {last_q[LOG2_TN-2:0], last_i};
   end

   // Valid pipeline register; cleared on reset so in-flight beats vanish.
   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q <= '0;
      end else begin
         valid_q <= valid_d;
      end
   end

   // Last flag pipeline; only meaningful where the matching valid bit is set.
   always_ff @(posedge clk) begin
      last_q <= last_d;
   end

   for (genvar l = 0; l < LOG2_TN; l++) begin : g_lvl
      localparam int IW  = N + l;
      localparam int OW  = N + l + 1;
      localparam int CNT = TN >> (l + 1);

      logic [2*CNT*IW-1:0] in_s;
      logic [CNT*OW-1:0]   sum_d;
      logic [CNT*OW-1:0]   sum_q;
      logic [IW-1:0]       a_s;
      logic [IW-1:0]       b_s;

      if (l == 0) begin : g_src_in
         assign in_s = prod_i;
      end else begin : g_src_prev
         assign in_s = g_lvl[l-1].sum_q;
      end

      // Pairwise sign-extended adds for this level.
      always_comb begin
         sum_d = '0;
         a_s   = '0;
         b_s   = '0;
         for (int j = 0; j < CNT; j++) begin
            a_s = in_s[(2*j)*IW +: IW];
            b_s = in_s[(2*j+1)*IW +: IW];
            sum_d[j*OW +: OW] = {a_s[IW-1], a_s} + {b_s[IW-1], b_s};
         end
      end

      // Level data register; no reset, qualified by the valid pipeline.
      always_ff @(posedge clk) begin
         sum_q <= sum_d;
      end
   end

   assign valid_o = valid_q[LOG2_TN-1];
   assign last_o  = last_q[LOG2_TN-1];
   assign sum_o   = g_lvl[LOG2_TN-1].sum_q;

endmodule

// File: rtl/n1_accum_unit.sv
// -----------------------------------------------------------------------------
// n1_accum_unit
// Reduces beats of TN signed products through a pipelined adder tree and
// accumulates the per-beat sums over an output window. The window closes on a
// beat flagged last: the total is saturated to N bits and presented for one
// cycle on o_valid, and the accumulator restarts from zero so the next beat
// can open a new window immediately. Accepts a beat every cycle; no stall.
// Ports:
//   clk      in   clock, all state updates on the rising edge
//   rst      in   synchronous active-high reset
//   i_valid  in   a beat of TN products is present
//   i_last   in   beat is the last of the window (ignored without i_valid)
//   i_prod   in   TN packed signed products, lane k at [(k+1)*N-1 : k*N]
//   o_valid  out  one-cycle pulse: o_sum/o_sat carry a completed window
//   o_sum    out  saturated N-bit window sum, held between pulses
//   o_sat    out  o_sum was clipped, held between pulses
// Latency from a last beat to its o_valid pulse: LOG2_TN + 1 cycles.
// -----------------------------------------------------------------------------
module n1_accum_unit
   import n1_pkg::*;
(
   input  logic            clk,
   input  logic            rst,
   input  logic            i_valid,
   input  logic            i_last,
   input  logic [TN*N-1:0] i_prod,
   output logic            o_valid,
   output logic [N-1:0]    o_sum,
   output logic            o_sat
);

   logic              tree_valid_s;
   logic              tree_last_s;
   logic [TREE_W-1:0] tree_sum_s;

   logic [WIDE_W-1:0] wide_sum_s;
   sat_n_t            sat_res_s;

   logic [ACC_W-1:0]  acc_q;
   logic [ACC_W-1:0]  acc_d;
   logic              o_valid_q;
   logic              o_valid_d;
   logic [N-1:0]      o_sum_q;
   logic [N-1:0]      o_sum_d;
   logic              o_sat_q;
   logic              o_sat_d;

   n1_add_tree u_tree (
      .clk     (clk),
      .rst     (rst),
      .valid_i (i_valid),
      .last_i  (i_last),
      .prod_i  (i_prod),
      .valid_o (tree_valid_s),
      .last_o  (tree_last_s),
      .sum_o   (tree_sum_s)
   );

   // Unsaturated running total and its N-bit clipped form.
   always_comb begin
      wide_sum_s = widen_sum(acc_q, tree_sum_s);
      sat_res_s  = sat_n(wide_sum_s);
   end

   // Accumulate / close-window decision.
   always_comb begin
      acc_d     = acc_q;
      o_valid_d = 1'b0;
      o_sum_d   = o_sum_q;
      o_sat_d   = o_sat_q;
      if (tree_valid_s) begin
         if (tree_last_s) begin
            // Close the window; the next beat starts from zero.
            o_valid_d = 1'b1;
            o_sum_d   = sat_res_s.value;
            o_sat_d   = sat_res_s.clipped;
            acc_d     = '0;
         end else begin
            acc_d     = sat_acc(wide_sum_s);
         end
      end else begin
         acc_d     = acc_q;
      end
   end

   // Accumulator and output registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         acc_q     <= '0;
         o_valid_q <= 1'b0;
         o_sum_q   <= '0;
         o_sat_q   <= 1'b0;
      end else begin
         acc_q     <= acc_d;
         o_valid_q <= o_valid_d;
         o_sum_q   <= o_sum_d;
         o_sat_q   <= o_sat_d;
      end
   end

   assign o_valid = o_valid_q;
   assign o_sum   = o_sum_q;
   assign o_sat   = o_sat_q;

endmodule

// File: tb/tb_n1_accum_unit.sv
// -----------------------------------------------------------------------------
// tb_n1_accum_unit
// Directed scenarios plus randomized traffic against a window-level model:
// every accepted beat's lane total is added to a model accumulator (clipped to
// 24 bits); a last beat schedules an expected pulse 5 cycles later carrying
// the 16-bit clipped total. Reset discards pending pulses and the window.
// -----------------------------------------------------------------------------
module tb_n1_accum_unit;

   localparam int LAT = 5;

   logic         clk;
   logic         rst;
   logic         i_valid;
   logic         i_last;
   logic [255:0] i_prod;
   logic         o_valid;
   logic [15:0]  o_sum;
   logic         o_sat;

   n1_accum_unit dut (
      .clk     (clk),
      .rst     (rst),
      .i_valid (i_valid),
      .i_last  (i_last),
      .i_prod  (i_prod),
      .o_valid (o_valid),
      .o_sum   (o_sum),
      .o_sat   (o_sat)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_vec  = 0;
   int n_miss = 0;
   int cyc    = 0;
   bit rst_seen = 1'b0;

   typedef struct {int due; int sum; bit sat;} exp_t;
   typedef struct {int cyc; int sum; bit sat;} pulse_t;
   exp_t   exp_q[$];
   pulse_t log_q[$];

   longint m_acc = 0;
   int     hold_sum = 0;
   bit     hold_sat = 1'b0;

   // Cycle index and the reset value seen at each edge.
   always @(posedge clk) begin
      cyc      <= cyc + 1;
      rst_seen <= rst;
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
      n_vec++;
      if (act !== expv) begin
         n_miss++;
         $display("FAIL %s @cyc %0d: got %0d, expected %0d", nm, cyc, $signed(act), $signed(expv));
      end
   endtask

   function automatic longint clamp(input longint x, input int bits);
      longint hi;
      longint lo;
      hi = (longint'(1) << (bits - 1)) - 1;
      lo = -(longint'(1) << (bits - 1));
      if (x > hi) return hi;
      else if (x < lo) return lo;
      else return x;
   endfunction

   function automatic int lane_sum(input logic [255:0] p);
      int s;
      s = 0;
      for (int k = 0; k < 16; k++) s += int'($signed(p[k*16 +: 16]));
      return s;
   endfunction

   function automatic logic [255:0] fill(input logic [15:0] v);
      logic [255:0] r;
      for (int k = 0; k < 16; k++) r[k*16 +: 16] = v;
      return r;
   endfunction

   // Drive one cycle of inputs and advance the window model.
   task automatic step(input bit r, input bit v, input bit l, input logic [255:0] p);
      longint s;
      exp_t   e;
      @(posedge clk);
      #1;
      rst     = r;
      i_valid = v;
      i_last  = l;
      i_prod  = p;
      if (r) begin
         while (exp_q.size() > 0 && exp_q[exp_q.size()-1].due > cyc) void'(exp_q.pop_back());
         m_acc = 0;
      end else if (v) begin
         s = m_acc + longint'(lane_sum(p));
         if (l) begin
            e.due = cyc + LAT;
            e.sum = int'(clamp(s, 16));
            e.sat = (clamp(s, 16) != s);
            exp_q.push_back(e);
            m_acc = 0;
         end else begin
            m_acc = clamp(s, 24);
         end
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, '0);
   endtask

   // Per-cycle comparison of the DUT outputs against the model.
   always @(negedge clk) begin
      bit exp_v;
      if (cyc >= 1) begin
         if (rst_seen) begin
            chk("rst_o_valid", 32'(o_valid), 32'd0);
            chk("rst_o_sum", 32'($signed(o_sum)), 32'd0);
            chk("rst_o_sat", 32'(o_sat), 32'd0);
            hold_sum = 0;
            hold_sat = 1'b0;
         end else begin
            exp_v = (exp_q.size() > 0) && (exp_q[0].due == cyc);
            chk("o_valid", 32'(o_valid), 32'(exp_v));
            if (exp_v) begin
               chk("o_sum", 32'($signed(o_sum)), 32'(exp_q[0].sum));
               chk("o_sat", 32'(o_sat), 32'(exp_q[0].sat));
               hold_sum = exp_q[0].sum;
               hold_sat = exp_q[0].sat;
               void'(exp_q.pop_front());
            end else begin
               chk("o_sum_hold", 32'($signed(o_sum)), 32'(hold_sum));
               chk("o_sat_hold", 32'(o_sat), 32'(hold_sat));
            end
         end
         if (o_valid === 1'b1) log_q.push_back('{cyc, int'($signed(o_sum)), o_sat});
      end
   end

   // Check that exactly one pulse was logged, at the given cycle and value.
   task automatic chk_one_pulse(input string nm, input int at, input int sum, input bit sat);
      chk({nm, "_count"}, 32'(log_q.size()), 32'd1);
      if (log_q.size() >= 1) begin
         chk({nm, "_cycle"}, 32'(log_q[0].cyc), 32'(at));
         chk({nm, "_sum"}, 32'(log_q[0].sum), 32'(sum));
         chk({nm, "_sat"}, 32'(log_q[0].sat), 32'(sat));
      end
   endtask

   initial begin
      int t;
      int t2;
      bit r;
      bit v;
      bit l;
      logic [255:0] p;
      int mode;
      int last_div;

      rst     = 1'b1;
      i_valid = 1'b0;
      i_last  = 1'b0;
      i_prod  = '0;

      // Model pinned against hand-computed values.
      chk("model_ones", 32'(lane_sum(fill(16'h0001))), 32'd16);
      chk("model_hundred", 32'(lane_sum(fill(16'h0064))), 32'd1600);
      chk("model_neg", 32'(lane_sum(fill(16'h8000))), -32'sd524288);
      chk("model_clamp16", 32'(clamp(64'd1048544, 16)), 32'd32767);
      chk("model_clamp24", 32'(clamp(64'd10485440, 24)), 32'd8388607);

      // Reset held two cycles, then quiet.
      step(1'b1, 1'b0, 1'b0, '0);
      step(1'b1, 1'b0, 1'b0, '0);
      log_q.delete();
      idle(10);
      chk("reset_no_pulse", 32'(log_q.size()), 32'd0);
      chk("reset_sum", 32'($signed(o_sum)), 32'd0);
      chk("reset_sat", 32'(o_sat), 32'd0);

      // Single tile of ones.
      log_q.delete();
      step(1'b0, 1'b1, 1'b1, fill(16'h0001));
      t = cyc;
      idle(8);
      chk_one_pulse("single", t + 5, 16, 1'b0);

      // Three beats of 100 with two-cycle bubbles.
      log_q.delete();
      step(1'b0, 1'b1, 1'b0, fill(16'd100));
      idle(2);
      step(1'b0, 1'b1, 1'b0, fill(16'd100));
      idle(2);
      step(1'b0, 1'b1, 1'b1, fill(16'd100));
      t = cyc;
      idle(8);
      chk_one_pulse("bubbles", t + 5, 4800, 1'b0);

      // Positive saturation.
      log_q.delete();
      step(1'b0, 1'b1, 1'b0, fill(16'h7FFF));
      step(1'b0, 1'b1, 1'b1, fill(16'h7FFF));
      t = cyc;
      idle(8);
      chk_one_pulse("sat_pos", t + 5, 32767, 1'b1);

      // Negative saturation from a single beat.
      log_q.delete();
      step(1'b0, 1'b1, 1'b1, fill(16'h8000));
      t = cyc;
      idle(8);
      chk_one_pulse("sat_neg", t + 5, -32768, 1'b1);

      // Back-to-back windows.
      log_q.delete();
      step(1'b0, 1'b1, 1'b1, fill(16'h0001));
      t = cyc;
      step(1'b0, 1'b1, 1'b1, fill(16'hFFFF));
      t2 = cyc;
      idle(8);
      chk("b2b_count", 32'(log_q.size()), 32'd2);
      if (log_q.size() == 2) begin
         chk("b2b_cycle0", 32'(log_q[0].cyc), 32'(t + 5));
         chk("b2b_sum0", 32'(log_q[0].sum), 32'd16);
         chk("b2b_cycle1", 32'(log_q[1].cyc), 32'(t2 + 5));
         chk("b2b_sum1", 32'(log_q[1].sum), -32'sd16);
      end

      // Reset in the middle of a window.
      log_q.delete();
      step(1'b0, 1'b1, 1'b0, fill(16'h0001));
      step(1'b0, 1'b1, 1'b0, fill(16'h0001));
      step(1'b1, 1'b0, 1'b0, '0);
      step(1'b0, 1'b1, 1'b1, fill(16'h0001));
      t = cyc;
      idle(10);
      chk_one_pulse("mid_rst", t + 5, 16, 1'b0);

      // Accumulator clips at 24 bits before the window swings back down.
      log_q.delete();
      for (int i = 0; i < 20; i++) step(1'b0, 1'b1, 1'b0, fill(16'h7FFF));
      for (int i = 0; i < 15; i++) step(1'b0, 1'b1, 1'b0, fill(16'h8000));
      step(1'b0, 1'b1, 1'b1, fill(16'h8000));
      t = cyc;
      idle(8);
      chk_one_pulse("acc_sat", t + 5, -1, 1'b0);

      // Randomized traffic: short windows first, then long ones.
      for (int i = 0; i < 4000; i++) begin
         last_div = (i < 2000) ? 4 : 40;
         r = ($urandom_range(0, 299) == 0);
         v = ($urandom_range(0, 3) != 0);
         l = ($urandom_range(0, last_div - 1) == 0);
         mode = $urandom_range(0, 3);
         for (int k = 0; k < 16; k++) begin
            case (mode)
               0: p[k*16 +: 16] = 16'($urandom);
               1: p[k*16 +: 16] = 16'h7FFF - 16'($urandom_range(0, 3));
               2: p[k*16 +: 16] = 16'h8000 + 16'($urandom_range(0, 3));
               default: p[k*16 +: 16] = 16'($signed(11'($urandom)));
            endcase
         end
         step(r, v, l, p);
      end
      idle(10);
      chk("queue_drained", 32'(exp_q.size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
